// File: rtl/fx3_gpio_master_if.sv
// GPIO loopback link between the FPGA-side master and the Fx3 responder.
// GPO/INTR travel to the Fx3; GPI/ACK come back on the same clock.
interface fx3_gpio_master_if;
  logic [22:0] GPO;
  logic        INTR;
  logic [22:0] GPI;
  logic        ACK;

  modport master (output GPO, output INTR, input GPI, input ACK);
  modport slave  (input GPO, input INTR, output GPI, output ACK);
endinterface

// File: rtl/fx3_gpio_master.sv
// Fx3 GPIO loopback initiator: sends LFSR test words framed by INTR, waits for
// the echoed word on GPI/ACK and records per-test pass/fail.
module fx3_gpio_master #(
  parameter int unsigned N_TESTS     = 31,
  parameter logic [22:0] SEED        = 23'h5A5A5A,
  parameter int unsigned ACK_TIMEOUT = 1000,
  parameter int unsigned GAP_CYCLES  = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  fx3_gpio_master_if.master  fx3,
  output logic [31:0]        result_reg,
  output logic [5:0]         err_count,
  output logic               timeout_seen,
  output logic               busy,
  output logic               done
);

  localparam int unsigned TW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam int unsigned GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [TW-1:0] TO_LAST  = TW'(ACK_TIMEOUT - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);
  localparam logic [4:0]    IDX_LAST = 5'(N_TESTS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEND,
    S_WAIT_ACK,
    S_CHECK,
    S_GAP,
    S_DONE
  } state_e;

  state_e        state_q, state_d;
  logic [22:0]   pattern_q, pattern_d;
  logic [22:0]   rx_q, rx_d;
  logic [22:0]   gpo_q, gpo_d;
  logic          intr_q, intr_d;
  logic [4:0]    idx_q, idx_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic          timed_out_q, timed_out_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [31:0]   result_q, result_d;
  logic [5:0]    err_q, err_d;
  logic          ts_q, ts_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          pass;
  logic [22:0]   pattern_next;

  // x^23 + x^18 + 1
  assign pattern_next = {pattern_q[21:0], pattern_q[22] ^ pattern_q[17]};

  always_comb begin
    state_d     = state_q;
    pattern_d   = pattern_q;
    rx_d        = rx_q;
    gpo_d       = gpo_q;
    intr_d      = 1'b1;
    idx_d       = idx_q;
    to_cnt_d    = to_cnt_q;
    timed_out_d = timed_out_q;
    gap_d       = gap_q;
    result_d    = result_q;
    err_d       = err_q;
    ts_d        = ts_q;
    busy_d      = busy_q;
    done_d      = done_q;
    pass        = 1'b0;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        gpo_d = '0;
        if (start) begin
          result_d  = '0;
          err_d     = '0;
          ts_d      = 1'b0;
          pattern_d = SEED;
          idx_d     = '0;
          busy_d    = 1'b1;
          done_d    = 1'b0;
          state_d   = S_SEND;
        end
      end

      S_SEND: begin
        intr_d      = 1'b0;
        gpo_d       = pattern_q;
        to_cnt_d    = '0;
        timed_out_d = 1'b0;
        state_d     = S_WAIT_ACK;
      end

      S_WAIT_ACK: begin
        if (!fx3.ACK) begin
          rx_d    = fx3.GPI;
          state_d = S_CHECK;
        end else if (to_cnt_q == TO_LAST) begin
          ts_d        = 1'b1;
          timed_out_d = 1'b1;
          state_d     = S_CHECK;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end

      S_CHECK: begin
        // rx_q is stale after a timeout; timed_out_q alone forces the fail
        pass            = (rx_q == pattern_q) && !timed_out_q;
        result_d[idx_q] = pass;
        if (!pass && (err_q != 6'd63)) err_d = err_q + 1'b1;
        pattern_d = pattern_next;
        idx_d     = idx_q + 1'b1;
        gpo_d     = '0;
        if (idx_q == IDX_LAST) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          gap_d   = '0;
          state_d = S_GAP;
        end
      end

      S_GAP: begin
        if (gap_q == GAP_LAST) state_d = S_SEND;
        else                   gap_d   = gap_q + 1'b1;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      pattern_q   <= '0;
      rx_q        <= '0;
      gpo_q       <= '0;
      intr_q      <= 1'b1;
      idx_q       <= '0;
      to_cnt_q    <= '0;
      timed_out_q <= 1'b0;
      gap_q       <= '0;
      result_q    <= '0;
      err_q       <= '0;
      ts_q        <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      pattern_q   <= pattern_d;
      rx_q        <= rx_d;
      gpo_q       <= gpo_d;
      intr_q      <= intr_d;
      idx_q       <= idx_d;
      to_cnt_q    <= to_cnt_d;
      timed_out_q <= timed_out_d;
      gap_q       <= gap_d;
      result_q    <= result_d;
      err_q       <= err_d;
      ts_q        <= ts_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign fx3.GPO      = gpo_q;
  assign fx3.INTR     = intr_q;
  assign result_reg   = result_q;
  assign err_count    = err_q;
  assign timeout_seen = ts_q;
  assign busy         = busy_q;
  assign done         = done_q;

endmodule
